fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of the team's async Gray-pointer FIFO between NUM_REQ requesters in the w_clk domain. Each requester gets a locked burst of up to BURST_MAX beats, or until it marks end of packet. The arbiter never issues a write while the FIFO reports full, so FIFO overflow cannot be raised by traffic through this block. It sits directly in front of the FIFO write port: wdata, wr_en and full are wired one-to-one.

## Interface
Parameters:
- WIDTH, 8, data width; must match FIFO WIDTH
- NUM_REQ, 4, number of requesters (2..16)
- BURST_MAX, 4, max beats per grant (1..FIFO_SIZE)
- STALL_MAX, 8, idle cycles tolerated inside a grant before forced release (≥1)

Ports:
- w_clk  in  1  write-domain clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  requester i has a beat on req_data slice i
- req_data  in  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- req_last  in  NUM_REQ  beat from requester i is last of its packet
- req_ready  out  NUM_REQ  beat from requester i accepted this cycle when valid&ready
- fifo_full  in  1  FIFO full flag (write domain)
- fifo_wr_en  out  1  FIFO write enable
- fifo_wdata  out  WIDTH  FIFO write data
- grant_valid  out  1  a requester currently holds the grant
- grant_id  out  $clog2(NUM_REQ)  index of granted requester; held after release

## Operation
- States: IDLE, GRANT.
- IDLE: if any req_valid, at the edge select the first set bit scanning upward from rr_ptr with wrap. Load grant_id, clear beat_cnt and stall_cnt, go to GRANT. If no req_valid, stay in IDLE.
- GRANT, combinational:
  - req_ready[grant_id] = ~fifo_full; all other req_ready = 0.
  - fifo_wr_en = req_valid[grant_id] & ~fifo_full.
  - fifo_wdata = req_data slice grant_id.
- Accepted beat (fifo_wr_en=1): beat_cnt+1, stall_cnt cleared.
- Release to IDLE on an accepted beat with req_last[grant_id]=1 or beat_cnt==BURST_MAX-1.
- Release to IDLE when stall_cnt reaches STALL_MAX-1. A cycle counts as stall when req_valid[grant_id]=0. Cycles with fifo_full=1 do not count.
- On every release: rr_ptr = grant_id+1, wrapping NUM_REQ-1 → 0.
- A burst cut by BURST_MAX resumes mid-packet at the requester's next grant. No packet atomicity is provided beyond BURST_MAX.
- Reset values: state IDLE, rr_ptr 0, grant_id 0, beat_cnt 0, stall_cnt 0. Outputs: req_ready all 0, fifo_wr_en 0, grant_valid 0, fifo_wdata = slice 0.
- rst during GRANT: grant dropped at that edge. A beat presented in the reset cycle is not written, because wr_en is forced 0 while rst=1.
- beat_cnt width: $clog2(BURST_MAX+1). stall_cnt width: $clog2(STALL_MAX+1). Neither saturates past its release compare.

## Timing
- Arbitration latency: req_valid first high in IDLE at cycle n → grant_valid=1 and first write possible at cycle n+1.
- One IDLE bubble cycle after every release. Peak throughput is BURST_MAX/(BURST_MAX+1) beats/cycle.
- Data path is zero-latency combinational from req_data to fifo_wdata within the grant.
- fifo_full is sampled combinationally. A full-to-not-full change is acted on in the same cycle.
- Handshake rules:
  - Requester holds req_valid/req_data/req_last stable until req_ready.
  - req_ready may assert while req_valid is low; this is not a transfer.
- Fairness: a continuously requesting input waits at most (NUM_REQ-1)*(BURST_MAX+1) accepted beats plus stall releases.

## Test plan
- Single requester 2, NUM_REQ=4, BURST_MAX=4, 6-beat packet 0x10..0x15 → grants of 4 then 2 beats. FIFO receives 0x10..0x15 in order. One IDLE cycle between grants. grant_id=2 both times.
- All four requesters valid continuously with 1-beat packets → grant_id sequence 0,1,2,3,0,… Each requester gets exactly one write per 8 cycles.
- fifo_full=1 for 5 cycles mid-burst from requester 1 → fifo_wr_en=0, req_ready[1]=0 throughout. No stall release. Burst resumes with no lost or duplicated beat.
- Requester 3 granted then drops req_valid, STALL_MAX=8 → release after 8 idle cycles. rr_ptr→0. Pending requester 0 granted next cycle.
- rst pulsed in GRANT after 2 beats → next cycle grant_valid=0, req_ready=0, fifo_wr_en=0. Rearbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Each grant is a locked burst ending on last beat, BURST_MAX beats, or a stall timeout.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 4,
    parameter int STALL_MAX = 8
) (
    input  logic                       w_clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_wdata,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int BEAT_W  = $clog2(BURST_MAX + 1);
    localparam int STALL_W = $clog2(STALL_MAX + 1);

    localparam logic [ID_W-1:0]    ID_LAST    = ID_W'(NUM_REQ - 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BURST_MAX - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic                pick_valid;
    logic [ID_W-1:0]     pick_id;
    logic                in_grant;
    logic                g_valid;
    logic                g_last;
    logic                accept;
    logic                stall;
    logic                release_grant;

    // Requester index base+off, wrapping modulo NUM_REQ (also correct for non-power-of-two NUM_REQ).
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = rr_ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[wrap_add(rr_ptr_q, i)]) begin
                pick_valid = 1'b1;
                pick_id    = wrap_add(rr_ptr_q, i);
            end
        end
    end

    assign in_grant = (state_q == GRANT);
    assign g_valid  = req_valid[grant_id_q];
    assign g_last   = req_last[grant_id_q];
    assign accept   = in_grant & g_valid & ~fifo_full & ~rst;
    assign stall    = in_grant & ~g_valid & ~fifo_full;

    assign fifo_wr_en  = accept;
    assign fifo_wdata  = req_data[grant_id_q*WIDTH +: WIDTH];
    assign grant_valid = in_grant;
    assign grant_id    = grant_id_q;

    always_comb begin
        req_ready = '0;
        if (in_grant && !rst) req_ready[grant_id_q] = ~fifo_full;
    end

    // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        beat_cnt_d    = beat_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        release_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = GRANT;
                    grant_id_d  = pick_id;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    beat_cnt_d  = beat_cnt_q + BEAT_W'(1);
                    stall_cnt_d = '0;
                    if (g_last || beat_cnt_q == BEAT_LAST) release_grant = 1'b1;
                end else if (stall) begin
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                    if (stall_cnt_q == STALL_LAST) release_grant = 1'b1;
                end
                if (release_grant) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_id_q == ID_LAST) ? '0 : grant_id_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge w_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
